// File: rtl/pc_update_unit.sv
// Program counter and next-PC select for the single-cycle CPU.
// Holds PC across memory stalls and counts retired instructions.
module pc_update_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          CNT_WIDTH    = 32,
    parameter int          UPDATE_DELAY = 1
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 JUMP,
    input  logic                 BRANCH,
    input  logic                 BRANCH_NE,
    input  logic                 ZERO,
    input  logic [31:0]          TARGET,
    input  logic                 BUSYWAIT,
    output logic [31:0]          PC,
    output logic [31:0]          PC_PLUS4,
    output logic                 STALLED,
    output logic [CNT_WIDTH-1:0] INSTR_COUNT
);

    // UPDATE_DELAY is a simulation-model delay only; registers update at the edge.
    if (UPDATE_DELAY < 0) begin : g_bad_delay
        $error("UPDATE_DELAY must be non-negative");
    end

    typedef enum logic [1:0] {
        S_HOLD  = 2'd0,
        S_RUN   = 2'd1,
        S_STALL = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [31:0]            r_pc;
    logic [31:0]            w_pc_nxt;
    logic [CNT_WIDTH-1:0]   r_cnt;
    logic [CNT_WIDTH-1:0]   w_cnt_nxt;
    logic                   r_pend_taken;
    logic                   w_pend_taken_nxt;
    logic [31:0]            r_pend_target;
    logic [31:0]            w_pend_target_nxt;
    logic [31:0]            r_pend_next4;
    logic [31:0]            w_pend_next4_nxt;
    logic                   w_taken;
    logic [31:0]            w_pc_plus4;

    assign w_taken    = JUMP | (BRANCH & ZERO) | (BRANCH_NE & ~ZERO);
    assign w_pc_plus4 = r_pc + 32'd4;

    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_cnt_nxt         = r_cnt;
        w_pend_taken_nxt  = r_pend_taken;
        w_pend_target_nxt = r_pend_target;
        w_pend_next4_nxt  = r_pend_next4;
        unique case (r_state)
            S_HOLD: begin
                w_state_nxt = BUSYWAIT ? S_STALL : S_RUN;
            end
            S_RUN: begin
                if (BUSYWAIT) begin
                    // Freeze the redirect decision seen at stall entry.
                    w_pend_taken_nxt  = w_taken;
                    w_pend_target_nxt = TARGET;
                    w_pend_next4_nxt  = w_pc_plus4;
                    w_state_nxt       = S_STALL;
                end else begin
                    w_pc_nxt  = w_taken ? TARGET : w_pc_plus4;
                    w_cnt_nxt = r_cnt + CNT_WIDTH'(1);
                end
            end
            S_STALL: begin
                if (!BUSYWAIT) begin
                    w_pc_nxt    = r_pend_taken ? r_pend_target : r_pend_next4;
                    w_cnt_nxt   = r_cnt + CNT_WIDTH'(1);
                    w_state_nxt = S_RUN;
                end
            end
            default: begin
                w_state_nxt = S_HOLD;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state       <= S_HOLD;
            r_pc          <= RESET_VECTOR;
            r_cnt         <= '0;
            r_pend_taken  <= 1'b0;
            r_pend_target <= 32'h0000_0000;
            // A stall leaving HOLD resumes at the reset vector.
            r_pend_next4  <= RESET_VECTOR;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_cnt         <= w_cnt_nxt;
            r_pend_taken  <= w_pend_taken_nxt;
            r_pend_target <= w_pend_target_nxt;
            r_pend_next4  <= w_pend_next4_nxt;
        end
    end

    assign PC          = r_pc;
    assign PC_PLUS4    = w_pc_plus4;
    assign STALLED     = (r_state == S_STALL);
    assign INSTR_COUNT = r_cnt;

endmodule

// File: tb/tb_pc_update_unit.sv
// Directed bench for pc_update_unit: reset, branch/jump select,
// stall freeze, reset mid-stall, PC and counter wrap.
module tb_pc_update_unit;

    logic        CLK;
    logic        RESET;
    logic        JUMP;
    logic        BRANCH;
    logic        BRANCH_NE;
    logic        ZERO;
    logic [31:0] TARGET;
    logic        BUSYWAIT;
    logic [31:0] PC;
    logic [31:0] PC_PLUS4;
    logic        STALLED;
    logic [31:0] INSTR_COUNT;
    logic [31:0] pc4;
    logic [31:0] pc4_plus4;
    logic        stalled4;
    logic [3:0]  cnt4;

    int n_chk = 0;
    int n_err = 0;

    pc_update_unit #(
        .RESET_VECTOR(32'h0000_0000),
        .CNT_WIDTH(32),
        .UPDATE_DELAY(1)
    ) u_dut (
        .CLK(CLK), .RESET(RESET), .JUMP(JUMP), .BRANCH(BRANCH),
        .BRANCH_NE(BRANCH_NE), .ZERO(ZERO), .TARGET(TARGET),
        .BUSYWAIT(BUSYWAIT), .PC(PC), .PC_PLUS4(PC_PLUS4),
        .STALLED(STALLED), .INSTR_COUNT(INSTR_COUNT)
    );

    pc_update_unit #(
        .RESET_VECTOR(32'h0000_0000),
        .CNT_WIDTH(4),
        .UPDATE_DELAY(1)
    ) u_dut4 (
        .CLK(CLK), .RESET(RESET), .JUMP(JUMP), .BRANCH(BRANCH),
        .BRANCH_NE(BRANCH_NE), .ZERO(ZERO), .TARGET(TARGET),
        .BUSYWAIT(BUSYWAIT), .PC(pc4), .PC_PLUS4(pc4_plus4),
        .STALLED(stalled4), .INSTR_COUNT(cnt4)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic ctl(input logic j, input logic b, input logic bne,
                       input logic z, input logic [31:0] t,
                       input logic bw);
        JUMP = j; BRANCH = b; BRANCH_NE = bne;
        ZERO = z; TARGET = t; BUSYWAIT = bw;
    endtask

    task automatic chk_pc(input string tag, input logic [31:0] epc,
                          input logic [31:0] ecnt, input logic est);
        check({tag, ".pc"}, PC, epc);
        check({tag, ".cnt"}, INSTR_COUNT, ecnt);
        check({tag, ".stl"}, {31'b0, STALLED}, {31'b0, est});
    endtask

    initial begin
        RESET = 1'b1;
        ctl(0, 0, 0, 0, 32'h0, 0);
        step();
        step();
        chk_pc("rst", 32'h0, 0, 0);
        check("rst.p4", PC_PLUS4, 32'h4);
        RESET = 1'b0;

        step();
        chk_pc("hold", 32'h0, 0, 0);
        step();
        chk_pc("seq1", 32'h4, 1, 0);
        step();
        chk_pc("seq2", 32'h8, 2, 0);
        step();
        chk_pc("seq3", 32'hC, 3, 0);
        step();
        chk_pc("seq4", 32'h10, 4, 0);

        ctl(0, 1, 0, 1, 32'h40, 0);
        step();
        chk_pc("beq_t", 32'h40, 5, 0);
        ctl(1, 0, 0, 0, 32'h10, 0);
        step();
        chk_pc("jmp10", 32'h10, 6, 0);
        ctl(0, 1, 0, 0, 32'h40, 0);
        step();
        chk_pc("beq_nt", 32'h14, 7, 0);
        ctl(0, 0, 1, 0, 32'h08, 0);
        step();
        chk_pc("bne_t", 32'h08, 8, 0);
        ctl(0, 0, 1, 1, 32'h80, 0);
        step();
        chk_pc("bne_nt", 32'h0C, 9, 0);
        ctl(1, 0, 0, 0, 32'h20, 0);
        step();
        chk_pc("jmp20", 32'h20, 10, 0);
        ctl(1, 1, 0, 0, 32'h100, 0);
        step();
        chk_pc("jmp_sim", 32'h100, 11, 0);
        ctl(1, 0, 0, 0, 32'h30, 0);
        step();
        chk_pc("jmp30", 32'h30, 12, 0);

        ctl(1, 0, 0, 0, 32'h80, 1);
        step();
        chk_pc("stl1", 32'h30, 12, 1);
        ctl(0, 0, 0, 0, 32'hDEAD_BEE0, 1);
        step();
        chk_pc("stl2", 32'h30, 12, 1);
        step();
        chk_pc("stl3", 32'h30, 12, 1);
        BUSYWAIT = 1'b0;
        step();
        chk_pc("stl_rel", 32'h80, 13, 0);
        ctl(0, 0, 0, 0, 32'h0, 0);
        step();
        chk_pc("post_stl", 32'h84, 14, 0);

        ctl(1, 0, 0, 0, 32'hFFFF_FFFC, 0);
        step();
        chk_pc("top", 32'hFFFF_FFFC, 15, 0);
        check("top.p4", PC_PLUS4, 32'h0);
        check("c4_15", {28'b0, cnt4}, 32'hF);
        ctl(0, 0, 0, 0, 32'h0, 0);
        step();
        chk_pc("wrap", 32'h0, 16, 0);
        check("c4_wrap", {28'b0, cnt4}, 32'h0);
        step();
        chk_pc("wrap1", 32'h4, 17, 0);

        ctl(1, 0, 0, 0, 32'h200, 1);
        step();
        chk_pc("mstl", 32'h4, 17, 1);
        RESET = 1'b1;
        step();
        chk_pc("mrst", 32'h0, 0, 0);
        check("mrst.c4", {28'b0, cnt4}, 32'h0);
        RESET = 1'b0;
        ctl(0, 0, 0, 0, 32'h0, 0);
        step();
        chk_pc("mhold", 32'h0, 0, 0);
        step();
        chk_pc("mrun", 32'h4, 1, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
